ema_threshold_detect: RTL and testbench



---
 rtl/ema_pkg.sv | 11 +
 rtl/axis_out_reg.sv | 27 ++
 rtl/ema_threshold_detect.sv | 55 +++++
 tb/tb_ema_threshold_detect.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ema_pkg.sv
// ema_pkg: shared widths, FSM state and event word layout for the EMA stages
package ema_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int IDX_WIDTH = 31;
  localparam int RUN_WIDTH = 8;
  typedef enum logic {LOW, HIGH} state_t;
  typedef struct packed {
    logic dir;
    logic [IDX_WIDTH-1:0] idx;
  } event_t;
endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: single-entry AXI4-Stream output register; ready is free whenever the slot is empty or draining
module axis_out_reg
  import ema_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  input  logic         m_ready
);
  logic load;
  assign s_ready = ~rst & (~m_valid | m_ready);
  assign load = s_valid & s_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_valid <= 1'b0;
      m_data <= '0;
    end else begin
      m_valid <= load | (m_valid & ~m_ready);
      if (load) m_data <= s_data;
    end
endmodule

// File: rtl/ema_threshold_detect.sv
// ema_threshold_detect: hysteresis threshold detector with consecutive-sample debounce
// emitting one event beat {direction, sample index} per debounced crossing
module ema_threshold_detect
  import ema_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] THRESH_HI = 32'h0000_0400,
  parameter logic [DATA_WIDTH-1:0] THRESH_LO = 32'h0000_0300,
  parameter int DEBOUNCE = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  state_o
);
  if (DEBOUNCE < 1 || DEBOUNCE > 255 || THRESH_LO >= THRESH_HI) begin : g_bad_params
    $error("ema_threshold_detect: DEBOUNCE must be 1..255 and THRESH_LO < THRESH_HI");
  end
  state_t state;
  logic [RUN_WIDTH-1:0] run_cnt, run_next;
  logic [IDX_WIDTH-1:0] idx;
  logic fire, qual, hit;
  event_t ev;
  assign fire = s_axis_tvalid & s_axis_tready;
  // in LOW we wait for high samples, in HIGH for low ones; in-band samples never qualify
  assign qual = (state == LOW) ? (s_axis_tdata >= THRESH_HI) : (s_axis_tdata <= THRESH_LO);
  assign run_next = run_cnt + 1'b1;
  assign hit = fire & qual & (run_next == RUN_WIDTH'(DEBOUNCE));
  assign ev = '{dir: state == LOW, idx: idx};
  assign state_o = state == HIGH;
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state <= LOW;
      run_cnt <= '0;
      idx <= '0;
    end else if (fire) begin
      idx <= idx + 1'b1;
      run_cnt <= (qual & ~hit) ? run_next : '0;
      if (hit) state <= (state == LOW) ? HIGH : LOW;
    end
  axis_out_reg #(.W(DATA_WIDTH)) u_out (
    .clk(ACLK),
    .rst(ARESET),
    .s_valid(hit),
    .s_data(ev),
    .s_ready(s_axis_tready),
    .m_valid(m_axis_tvalid),
    .m_data(m_axis_tdata),
    .m_ready(m_axis_tready)
  );
endmodule

// File: tb/tb_ema_threshold_detect.sv
// tb_ema_threshold_detect: scoreboard bench for two detector instances (debounce 2 and 1)
module tb_ema_threshold_detect;
  localparam logic [31:0] HI = 32'h400;
  localparam logic [31:0] LO = 32'h300;

  logic ACLK = 0;
  logic ARESET = 1;
  logic [1:0] s_valid = '0;
  logic [1:0][31:0] s_data = '0;
  logic [1:0] m_ready = '0;
  wire [1:0] s_ready, m_valid, state;
  wire [1:0][31:0] m_data;

  int vectors = 0, miscompares = 0, cyc = 0;

  logic [31:0] exp_q[2][$];
  logic [31:0] obs_q[2][$];
  int obs_cyc[2][$];
  logic [31:0] hist[2][$];
  logic lvl[2];
  logic [30:0] idx[2];
  logic prev_valid[2], prev_mready[2];
  logic [31:0] prev_data[2];
  logic [1:0] held;

  ema_threshold_detect #(.THRESH_HI(HI), .THRESH_LO(LO), .DEBOUNCE(2)) u_db2 (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axis_tdata(s_data[0]), .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]),
    .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]),
    .state_o(state[0]));
  ema_threshold_detect #(.THRESH_HI(HI), .THRESH_LO(LO), .DEBOUNCE(1)) u_db1 (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axis_tdata(s_data[1]), .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]),
    .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]),
    .state_o(state[1]));

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic int dbf(input int d);
    return d == 0 ? 2 : 1;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  // Reference: a crossing fires when the last DEBOUNCE samples since the previous
  // crossing all lie on the far side of the threshold for the current level.
  always @(negedge ACLK) begin
    for (int d = 0; d < 2; d++) begin
      if (ARESET) begin
        chk("reset_tvalid", d, 32'(m_valid[d]), 0);
        chk("reset_tdata", d, m_data[d], 0);
        chk("reset_state", d, 32'(state[d]), 0);
        chk("reset_tready", d, 32'(s_ready[d]), 0);
        exp_q[d].delete();
        hist[d].delete();
        lvl[d] = 0;
        idx[d] = 0;
        prev_valid[d] = 0;
      end else begin
        chk("state", d, 32'(state[d]), 32'(lvl[d]));
        if (prev_valid[d] && !prev_mready[d]) begin
          chk("hold_valid", d, 32'(m_valid[d]), 1);
          chk("hold_data", d, m_data[d], prev_data[d]);
        end
        if (m_valid[d] && m_ready[d]) begin
          obs_q[d].push_back(m_data[d]);
          obs_cyc[d].push_back(cyc);
          if (exp_q[d].size() == 0) chk("unexpected_event", d, m_data[d], 32'hxxxx_xxxx);
          else chk("event", d, m_data[d], exp_q[d].pop_front());
        end
        if (s_valid[d] && s_ready[d]) begin
          logic all;
          hist[d].push_back(s_data[d]);
          if (hist[d].size() > dbf(d)) void'(hist[d].pop_front());
          all = hist[d].size() == dbf(d);
          foreach (hist[d][k]) all &= lvl[d] ? (hist[d][k] <= LO) : (hist[d][k] >= HI);
          if (all) begin
            exp_q[d].push_back({~lvl[d], idx[d]});
            lvl[d] = ~lvl[d];
            hist[d].delete();
          end
          idx[d] = idx[d] + 1'b1;
        end
        prev_valid[d] = m_valid[d];
        prev_mready[d] = m_ready[d];
        prev_data[d] = m_data[d];
      end
    end
  end

  task automatic send(input int d, input logic [31:0] x);
    s_data[d] = x;
    s_valid[d] = 1;
    for (int t = 0; ; t++) begin
      @(negedge ACLK);
      if (s_ready[d]) break;
      if (t > 200) begin
        chk("send_timeout", d, 0, 1);
        break;
      end
    end
    @(posedge ACLK);
    #1 s_valid[d] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic clear_obs();
    for (int d = 0; d < 2; d++) begin
      obs_q[d].delete();
      obs_cyc[d].delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] b2b[3];
    b2b = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0002};
    repeat (20) @(posedge ACLK);
    #1 ARESET = 0;
    @(negedge ACLK);
    chk("ready_after_reset", 0, 32'(s_ready[0]), 1);
    chk("ready_after_reset", 1, 32'(s_ready[1]), 1);
    @(posedge ACLK);
    #1 m_ready = 2'b11;

    clear_obs();
    foreach (b2b[i]) ;
    send(0, 32'h3E8); send(0, 32'h410); send(0, 32'h3FF); send(0, 32'h420); send(0, 32'h430);
    idle(3);
    chk("rise_count", 0, obs_q[0].size(), 1);
    if (obs_q[0].size() > 0) chk("rise_word", 0, obs_q[0][0], 32'h8000_0004);
    chk("rise_state", 0, 32'(state[0]), 1);

    clear_obs();
    send(0, 32'h350); send(0, 32'h300); send(0, 32'h2F0);
    idle(3);
    chk("fall_count", 0, obs_q[0].size(), 1);
    if (obs_q[0].size() > 0) chk("fall_word", 0, obs_q[0][0], 32'h0000_0007);
    chk("fall_state", 0, 32'(state[0]), 0);

    clear_obs();
    m_ready[0] = 0;
    send(0, 32'h500); send(0, 32'h500);
    s_data[0] = 32'h100;
    s_valid[0] = 1;
    repeat (5) begin
      @(negedge ACLK);
      chk("bp_tready", 0, 32'(s_ready[0]), 0);
      chk("bp_tdata", 0, m_data[0], 32'h8000_0009);
    end
    @(posedge ACLK);
    #1 m_ready[0] = 1;
    @(negedge ACLK);
    chk("bp_resume_tready", 0, 32'(s_ready[0]), 1);
    chk("bp_resume_tvalid", 0, 32'(m_valid[0]), 1);
    @(posedge ACLK);
    #1 s_valid[0] = 0;
    idle(3);
    chk("bp_count", 0, obs_q[0].size(), 1);

    clear_obs();
    send(1, 32'h500); send(1, 32'h100); send(1, 32'h500);
    idle(3);
    chk("b2b_count", 1, obs_q[1].size(), 3);
    if (obs_q[1].size() == 3)
      for (int i = 0; i < 3; i++) begin
        chk("b2b_word", 1, obs_q[1][i], b2b[i]);
        if (i > 0) chk("b2b_gap", 1, obs_cyc[1][i] - obs_cyc[1][i-1], 1);
      end

    m_ready[1] = 0;
    send(1, 32'h100);
    idle(1);
    chk("pending_before_reset", 1, 32'(m_valid[1]), 1);
    ARESET = 1;
    idle(3);
    ARESET = 0;
    m_ready = 2'b11;
    clear_obs();
    send(1, 32'h500);
    send(0, 32'h100);
    idle(3);
    chk("post_reset_count", 1, obs_q[1].size(), 1);
    if (obs_q[1].size() > 0) chk("post_reset_word", 1, obs_q[1][0], 32'h8000_0000);
    chk("post_reset_none", 0, obs_q[0].size(), 0);
    chk("post_reset_state", 0, 32'(state[0]), 0);

    held = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge ACLK);
      held = s_valid & ~s_ready;
      @(posedge ACLK);
      #1;
      for (int d = 0; d < 2; d++) begin
        m_ready[d] = ($urandom % 3) != 0;
        if (!held[d]) begin
          s_valid[d] = ($urandom % 4) != 0;
          case ($urandom % 6)
            0: s_data[d] = $urandom;
            1: s_data[d] = ($urandom % 2) ? HI : LO;
            default: s_data[d] = $urandom_range(32'h480, 32'h280);
          endcase
        end
      end
    end
    s_valid = '0;
    m_ready = 2'b11;
    idle(6);
    chk("drain_empty", 0, exp_q[0].size(), 0);
    chk("drain_empty", 1, exp_q[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
